hazard_scoreboard_ctrl: RTL

//  Issue controller for the 5-stage core: decides each cycle whether the instruction in ID may issue to EX.

---
 rtl/core_isa_pkg.sv | 48 ++++
 rtl/hazard_scoreboard_ctrl_if.sv | 26 ++
 rtl/reg_pend_counter.sv | 27 ++
 rtl/hazard_scoreboard_ctrl.sv | 86 ++++++++
 4 files changed

// File: rtl/core_isa_pkg.sv
// ISA constants and decode helpers shared by the core's ID-stage logic.
package core_isa_pkg;

   localparam logic [5:0] OP_ADD  = 6'b000000;
   localparam logic [5:0] OP_SUB  = 6'b000001;
   localparam logic [5:0] OP_AND  = 6'b000010;
   localparam logic [5:0] OP_OR   = 6'b000011;
   localparam logic [5:0] OP_CMP  = 6'b000100;
   localparam logic [5:0] OP_MUL  = 6'b000101;
   localparam logic [5:0] OP_LW   = 6'b001000;
   localparam logic [5:0] OP_SW   = 6'b001001;
   localparam logic [5:0] OP_ADDI = 6'b001010;
   localparam logic [5:0] OP_SUBI = 6'b001011;
   localparam logic [5:0] OP_CMPI = 6'b001100;
   localparam logic [5:0] OP_HLT  = 6'b111111;

   typedef enum logic [2:0] {RR_ALU, RM_ALU, LOAD, STORE, HALT} instr_type_e;

   function automatic logic [5:0] ir_opcode(input logic [31:0] ir);
      return ir[31:26];
   endfunction

   function automatic logic [4:0] ir_rs(input logic [31:0] ir);
      return ir[25:21];
   endfunction

   function automatic logic [4:0] ir_rt(input logic [31:0] ir);
      return ir[20:16];
   endfunction

   function automatic logic [4:0] ir_rd(input logic [31:0] ir);
      return ir[15:11];
   endfunction

   // Undefined opcodes decode as HALT so a bad fetch stops the core.
   function automatic instr_type_e decode_type(input logic [5:0] op);
      instr_type_e t;
      case (op)
         OP_ADD, OP_SUB, OP_AND, OP_OR, OP_CMP, OP_MUL: t = RR_ALU;
         OP_ADDI, OP_SUBI, OP_CMPI:                     t = RM_ALU;
         OP_LW:                                         t = LOAD;
         OP_SW:                                         t = STORE;
         default:                                       t = HALT;
      endcase
      return t;
   endfunction

endpackage

// File: rtl/hazard_scoreboard_ctrl_if.sv
// ID/WB-side signal bundle of the issue controller.
interface hazard_scoreboard_ctrl_if #(
   parameter int unsigned CNT_W = 16
);
   logic             id_valid;
   logic [31:0]      id_ir;
   logic             wb_valid;
   logic [4:0]       wb_dst;
   logic             flush;
   logic             id_stall;
   logic             issue;
   logic             halted;
   logic [31:0]      pending;
   logic [CNT_W-1:0] stall_cnt;
   logic             err_underflow;

   modport master (
      output id_valid, id_ir, wb_valid, wb_dst, flush,
      input  id_stall, issue, halted, pending, stall_cnt, err_underflow
   );

   modport slave (
      input  id_valid, id_ir, wb_valid, wb_dst, flush,
      output id_stall, issue, halted, pending, stall_cnt, err_underflow
   );
endinterface

// File: rtl/reg_pend_counter.sv
// Outstanding-write counter for one architectural register.
module reg_pend_counter #(
   parameter int unsigned PEND_W = 2
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              inc,
   input  logic              dec,
   input  logic              clr,
   output logic [PEND_W-1:0] count,
   output logic              underflow
);

   // A decrement that finds the count already empty is a WB with no matching issue.
   assign underflow = dec && (count == '0);

   always_ff @(posedge clk) begin
      if (rst || clr) begin
         count <= '0;
      end else if (inc && !dec) begin
         count <= count + PEND_W'(1);
      end else if (dec && !inc && (count != '0)) begin
         count <= count - PEND_W'(1);
      end
   end

endmodule

// File: rtl/hazard_scoreboard_ctrl.sv
// ID-stage issue controller: RAW scoreboard, halt latch and stall-cycle counter.
module hazard_scoreboard_ctrl
   import core_isa_pkg::*;
#(
   parameter int unsigned PEND_W = 2,
   parameter int unsigned CNT_W  = 16
) (
   input logic                     clk,
   input logic                     rst,
   hazard_scoreboard_ctrl_if.slave bus
);

   instr_type_e       itype;
   logic [4:0]        rs, rt, dst;
   logic              reads_rs, reads_rt, writes, halting;
   logic [PEND_W-1:0] cnt [32];
   logic [31:0]       pend;
   logic [31:0]       uflow;
   logic              src_hazard, dst_full, stall, issue_now;
   logic              halted_r, err_r;
   logic [CNT_W-1:0]  stall_cnt_r;
   logic              unused_ir;

   assign unused_ir = ^bus.id_ir[10:0];

   always_comb begin
      itype    = decode_type(ir_opcode(bus.id_ir));
      rs       = ir_rs(bus.id_ir);
      rt       = ir_rt(bus.id_ir);
      reads_rs = (itype != HALT);
      reads_rt = (itype == RR_ALU) || (itype == STORE);
      writes   = (itype == RR_ALU) || (itype == RM_ALU) || (itype == LOAD);
      halting  = (itype == HALT);
      dst      = (itype == RR_ALU) ? ir_rd(bus.id_ir) : rt;
   end

   assign cnt[0]   = '0;
   assign uflow[0] = 1'b0;

   for (genvar r = 1; r < 32; r++) begin : g_cnt
      reg_pend_counter #(
         .PEND_W(PEND_W)
      ) u_cnt (
         .clk      (clk),
         .rst      (rst),
         .inc      (issue_now && writes && (dst == 5'(r))),
         .dec      (bus.wb_valid && (bus.wb_dst == 5'(r))),
         .clr      (bus.flush),
         .count    (cnt[r]),
         .underflow(uflow[r])
      );
   end

   always_comb begin
      pend = '0;
      for (int i = 0; i < 32; i++) begin
         pend[i] = |cnt[i];
      end
   end

   // Counts are taken at the start of the cycle, so a same-cycle WB never releases a stall.
   assign src_hazard = (reads_rs && pend[rs]) || (reads_rt && pend[rt]);
   assign dst_full   = writes && (dst != 5'd0) && (cnt[dst] == {PEND_W{1'b1}});
   assign stall      = bus.id_valid && (halted_r || src_hazard || dst_full);
   assign issue_now  = bus.id_valid && !stall;

   always_ff @(posedge clk) begin
      if (rst) begin
         halted_r    <= 1'b0;
         err_r       <= 1'b0;
         stall_cnt_r <= '0;
      end else begin
         if (issue_now && halting) halted_r <= 1'b1;
         if (|uflow) err_r <= 1'b1;
         if (stall && (stall_cnt_r != '1)) stall_cnt_r <= stall_cnt_r + CNT_W'(1);
      end
   end

   assign bus.id_stall      = stall;
   assign bus.issue         = issue_now;
   assign bus.halted        = halted_r;
   assign bus.pending       = pend;
   assign bus.stall_cnt     = stall_cnt_r;
   assign bus.err_underflow = err_r;

endmodule
